prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader for the 8-bit CPU. Receives a framed program image over a valid/ready byte interface and writes it into the 16-word instruction RAM through a dedicated write port. Holds the CPU in reset while loading and releases it only after a checksum-verified image is in memory. Sits between the board-level byte source (UART receiver or test bench) and the instruction memory's write side, the writer counterpart to the CPU's instruction fetch.

## Interface
Parameters:
- DATA_W, 8, instruction/byte width.
- ADDR_W, 4, instruction RAM address width (16 words).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid & in_ready.
- reload  input  1  single-cycle request to abort or re-enter loading.
- imem_we  output  1  instruction RAM write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  8  write data.
- cpu_rst  output  1  reset to CPU; high while not running.
- done  output  1  image loaded and verified; CPU running.
- err  output  1  framing or checksum error latched.
- words_loaded  output  5  payload count of the last accepted frame (0..16).

## Operation
- Frame format: header 0xA5, length N (1..16), N payload bytes written to addresses 0..N-1, checksum C such that (sum of payload + C) mod 256 == 0.
- States: WAIT_HDR, LEN, DATA, CSUM, RUN, ERR.
- WAIT_HDR: accepts a byte; 0xA5 -> LEN; any other byte is discarded, no state change.
- LEN: N == 0 or N > 16 -> ERR; otherwise store N, clear address counter and 8-bit sum, -> DATA.
- DATA: each accepted byte is written to imem_addr = counter, added to sum mod 256, counter++; after the Nth byte -> CSUM.
- CSUM: (sum + C) mod 256 == 0 -> RUN, set words_loaded = N; otherwise -> ERR.
- RUN: in_ready = 0, cpu_rst = 0, done = 1. Words at addresses >= N keep their previous contents.
- ERR: err = 1, cpu_rst = 1, in_ready = 1. A 0xA5 byte clears err and -> LEN. Other bytes are discarded.
- reload: from any state -> WAIT_HDR, cpu_rst = 1, done = 0, err = 0, counters cleared. words_loaded is retained.
- in_ready = 0 in RUN and in any cycle in which reload is high. reload wins over a simultaneous byte, and no byte is consumed.
- A failed or aborted frame can leave RAM partially overwritten. The CPU never runs from it because cpu_rst remains high.

## Timing
- Reset values: state WAIT_HDR, cpu_rst 1, done 0, err 0, imem_we 0, imem_addr 0, imem_wdata 0, words_loaded 0. in_ready is 1 immediately after reset release.
- in_ready is combinational from state and reload.
- Writes are registered: imem_we, imem_addr and imem_wdata are valid for exactly one cycle, the cycle after the payload handshake. Back-to-back bytes give back-to-back writes.
- cpu_rst falls and done rises in the cycle after the checksum handshake. By then the last imem write has completed, in the same cycle as the transition.
- err rises in the cycle after the offending LEN or CSUM byte is accepted.
- Throughput: one byte per cycle, with no bubbles between states.
- Asynchronous rst mid-frame returns all outputs to their reset values immediately. Any in-flight write strobe is dropped.

## Structure
- Shared package prog_loader_pkg holds:
  - the state enum (WAIT_HDR, LEN, DATA, CSUM, RUN, ERR);
  - HDR_BYTE = 8'hA5;
  - MAX_WORDS = 16.
- Single module; no sub-module. The checksum accumulator and address counter are inline registers.
- The instruction memory gains a synchronous write port (we/addr/wdata). The CPU's read port is unchanged.

## Test plan
- Good frame, continuous valid: A5 02 11 22 CD -> writes (0,0x11), (1,0x22) on consecutive cycles. cpu_rst falls one cycle after CD. done = 1, words_loaded = 2.
- Bad checksum: A5 01 40 00 -> one write (0,0x40), err = 1, cpu_rst stays 1. A following A5 01 40 C0 -> done = 1.
- Length errors: A5 00 and A5 11 -> err = 1 with no writes. Leading garbage 3C 7E before A5 is discarded without error.
- Stalled source: same frame as the first scenario with in_valid toggling every other cycle -> identical writes and result. No write occurs in cycles without a handshake.
- reload mid-DATA, asserted concurrently with in_valid: the byte is not consumed, state returns to WAIT_HDR. A full 16-word frame then loads addresses 0..15 and releases the CPU.
- Asynchronous rst asserted during DATA, between clock edges -> outputs return to reset values immediately. reload in RUN -> cpu_rst rises the next cycle, done = 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the framed program loader: FSM states and frame constants.
package prog_loader_pkg;
  typedef enum logic [2:0] {WAIT_HDR, LEN, DATA, CSUM, RUN, ERR} state_t;
  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam int         MAX_WORDS = 16;
endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses A5/len/payload/checksum frames, writes the
// instruction RAM and holds the CPU in reset until a verified image is present.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [4:0]        words_loaded
);

  state_t            state, state_n;
  logic [4:0]        len;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] csum_total;
  logic              acc;
  logic              len_bad;
  logic              last_word;

  assign in_ready   = (state != RUN) && !reload;
  assign acc        = in_valid && in_ready;
  assign cpu_rst    = (state != RUN);
  assign done       = (state == RUN);
  assign err        = (state == ERR);
  assign csum_total = sum + in_data;
  assign len_bad    = (in_data == '0) || (in_data > DATA_W'(MAX_WORDS));
  assign last_word  = (5'(cnt + 5'd1) == len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_HDR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (reload) begin
      state_n = WAIT_HDR;
    end else if (acc) begin
      case (state)
        WAIT_HDR: if (in_data == HDR_BYTE) state_n = LEN;
        LEN:      state_n = len_bad ? ERR : DATA;
        DATA:     if (last_word) state_n = CSUM;
        CSUM:     state_n = (csum_total == '0) ? RUN : ERR;
        ERR:      if (in_data == HDR_BYTE) state_n = LEN;
        default:  state_n = state;
      endcase
    end
  end

  // Write strobe is a one-cycle pulse; addr/wdata hold their last value between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      len          <= '0;
      cnt          <= '0;
      sum          <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        cnt <= '0;
        sum <= '0;
      end else if (acc) begin
        case (state)
          LEN: begin
            len <= in_data[4:0];
            cnt <= '0;
            sum <= '0;
          end
          DATA: begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt[ADDR_W-1:0];
            imem_wdata <= in_data;
            sum        <= csum_total;
            cnt        <= cnt + 5'd1;
          end
          CSUM: if (csum_total == '0) words_loaded <= len;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: a frame-level reference model
// predicts RAM writes and status; a separate monitor checks every write strobe.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       reload = 1'b0;
  logic       imem_we;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_rst, done, err;
  logic [4:0] words_loaded;

  prog_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where in the frame we are, plus the payload collected so far.
  typedef enum {M_HUNT, M_LEN, M_PAY, M_CHK, M_RUN, M_BAD} mphase_t;
  mphase_t    ph = M_HUNT;
  int         n_exp = 0;
  int         wl = 0;
  logic [7:0] pay[$];
  logic [11:0] wq[$];   // {addr, data} expected writes
  int         writes_seen = 0;

  task automatic model_reset();
    ph = M_HUNT; n_exp = 0; wl = 0; pay.delete(); wq.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic rl);
    int s;
    logic rdy;
    rdy = (ph != M_RUN) && !rl;
    check("in_ready", in_ready, rdy);
    if (rl) begin
      ph = M_HUNT;
    end else if (v && rdy) begin
      case (ph)
        M_HUNT, M_BAD: if (d == 8'hA5) ph = M_LEN;
        M_LEN: begin
          if (d == 0 || d > 16) ph = M_BAD;
          else begin n_exp = d; pay.delete(); ph = M_PAY; end
        end
        M_PAY: begin
          wq.push_back({4'(pay.size()), d});
          pay.push_back(d);
          if (pay.size() == n_exp) ph = M_CHK;
        end
        M_CHK: begin
          s = d;
          foreach (pay[i]) s += pay[i];
          if (s % 256 == 0) begin ph = M_RUN; wl = n_exp; end
          else ph = M_BAD;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_status();
    check("cpu_rst", cpu_rst, ph != M_RUN);
    check("done", done, ph == M_RUN);
    check("err", err, ph == M_BAD);
    check("words_loaded", words_loaded, wl);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic rl);
    @(negedge clk);
    check_status();
    in_valid = v; in_data = d; reload = rl;
    #1;
    model_step(v, d, rl);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    if ($urandom_range(99) < stall_pct) cycle(1'b0, 8'($urandom), 1'b0);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int stall_pct);
    foreach (f[i]) send_byte(f[i], stall_pct);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reload();
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      writes_seen++;
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: addr %0h data %0h at %0t", imem_addr, imem_wdata, $time);
      end else begin
        logic [11:0] e;
        e = wq.pop_front();
        check("write_addr", imem_addr, e[11:8]);
        check("write_data", imem_wdata, e[7:0]);
      end
    end
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] ps;
    int n, ws0;

    // Reset state while rst is held
    #3;
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, 4'h0);
    check("rst_wdata", imem_wdata, 8'h00);
    check("rst_wl", words_loaded, 5'd0);
    #20 rst = 1'b0;

    // Good frame, continuous
    ws0 = writes_seen;
    send_frame('{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCD}, 0);
    check("good_writes", writes_seen - ws0, 2);
    check("good_done", done, 1'b1);
    check("good_wl", words_loaded, 5'd2);
    cycle(1'b1, 8'h55, 1'b0);   // ignored in RUN
    do_reload();
    check("reload_cpu_rst", cpu_rst, 1'b1);

    // Bad checksum then corrected frame
    send_frame('{8'hA5, 8'h01, 8'h40, 8'h00}, 0);
    check("badcs_err", err, 1'b1);
    send_frame('{8'hA5, 8'h01, 8'h40, 8'hC0}, 0);
    check("fixcs_done", done, 1'b1);
    check("fixcs_wl", words_loaded, 5'd1);
    do_reload();

    // Length errors and leading garbage
    ws0 = writes_seen;
    send_frame('{8'hA5, 8'h00}, 0);
    check("len0_err", err, 1'b1);
    do_reload();
    send_frame('{8'hA5, 8'h11}, 0);
    check("len17_err", err, 1'b1);
    check("len_nowrites", writes_seen - ws0, 0);
    do_reload();
    send_frame('{8'h3C, 8'h7E}, 0);
    check("garbage_noerr", err, 1'b0);
    send_frame('{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCD}, 100);   // stalled source
    check("stall_done", done, 1'b1);
    do_reload();

    // reload mid-DATA with a concurrent byte, then a full 16-word frame
    send_frame('{8'hA5, 8'h04, 8'h01}, 0);
    cycle(1'b1, 8'h02, 1'b1);
    f = '{8'hA5, 8'h10};
    ps = 0;
    for (int i = 0; i < 16; i++) begin f.push_back(8'(i * 7 + 3)); ps += 8'(i * 7 + 3); end
    f.push_back(8'(-ps));
    send_frame(f, 0);
    check("full_done", done, 1'b1);
    check("full_wl", words_loaded, 5'd16);
    do_reload();

    // Async reset mid-DATA, right after a write strobe appears
    send_frame('{8'hA5, 8'h03, 8'h9A}, 0);
    cycle(1'b1, 8'h9B, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("arst_we", imem_we, 1'b0);
    check("arst_addr", imem_addr, 4'h0);
    check("arst_wdata", imem_wdata, 8'h00);
    check("arst_cpu_rst", cpu_rst, 1'b1);
    check("arst_wl", words_loaded, 5'd0);
    model_reset();
    in_valid = 1'b0;
    #1 rst = 1'b0;

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      int sp, kind, abort_at;
      f.delete();
      sp = $urandom_range(60);
      if ($urandom_range(3) == 0) f.push_back(8'($urandom_range(8'hA4)));
      f.push_back(8'hA5);
      kind = $urandom_range(9);
      n = (kind == 0) ? ($urandom_range(1) ? 0 : $urandom_range(17, 255)) : $urandom_range(1, 16);
      f.push_back(8'(n));
      ps = 0;
      if (n >= 1 && n <= 16) begin
        for (int i = 0; i < n; i++) begin f.push_back(8'($urandom)); ps += f[f.size()-1]; end
        f.push_back((kind == 1) ? 8'(-ps + 1) : 8'(-ps));
      end
      abort_at = ($urandom_range(7) == 0) ? $urandom_range(f.size() - 1) : -1;
      foreach (f[i]) begin
        if (i == abort_at) cycle(1'b1, f[i], 1'b1);
        else send_byte(f[i], sp);
      end
      cycle(1'b0, 8'h00, 1'b0);
      if (ph == M_RUN || $urandom_range(4) == 0) do_reload();
    end

    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("pending_writes", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
